// File: rtl/ksa_chunk_seq_pkg.sv
// Shared types for the chunked KSA sequencer: FSM state encoding and slice-index width helper.
package ksa_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ksa_seq_state_t;

  // A one-bit index is kept even for degenerate slice counts so the index never has zero width.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/ksa_chunk_seq_ksa.sv
// Combinational Kogge-Stone adder: s = a + b + cin, with s[BITS] as the carry-out.
module ksa_chunk_seq_ksa #(
  parameter int BITS   = 16,
  parameter int LEVELS = $clog2(BITS)
) (
  output logic [BITS:0]   s,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin
);

  logic [BITS-1:0] x, g, p, gn, pn;

  always_comb begin
    x = a ^ b;
    g = a & b;
    p = x;
    // Fold the carry-in into bit 0 so every prefix g[i] becomes the carry out of bit i.
    g[0] = g[0] | (x[0] & cin);
    gn = g;
    pn = p;
    for (int l = 0; l < LEVELS; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < BITS; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
    s = {g[BITS-1], x ^ {g[BITS-2:0], cin}};
  end

endmodule

// File: rtl/ksa_chunk_seq.sv
// Wide adder that streams CHUNK-bit slices through one shared KSA, chaining the carry in a register.
// Optional subtract mode (op port) is enabled by defining KSA_SEQ_SUB_EN.
module ksa_chunk_seq
  import ksa_seq_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CHUNK  = 16,
  parameter int LEVELS = $clog2(CHUNK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef KSA_SEQ_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  ksa_seq_state_t state, state_next;

  logic [IW-1:0]    idx;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   sum_q;
  logic [CHUNK:0]   ks;
  logic             sub;

`ifdef KSA_SEQ_SUB_EN
  assign sub = op;
`else
  assign sub = 1'b0;
`endif

  ksa_chunk_seq_ksa #(
    .BITS   (CHUNK),
    .LEVELS (LEVELS)
  ) u_ksa (
    .s   (ks),
    .a   (a_q[idx*CHUNK +: CHUNK]),
    .b   (b_q[idx*CHUNK +: CHUNK]),
    .cin (carry_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)         state_next = RUN;
      RUN:     if (idx == LAST)      state_next = DONE;
      DONE:    if (out_ready)        state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Subtract is a + ~b + 1, so the incoming carry is forced and cin ignored.
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          carry_q <= sub ? 1'b1 : cin;
          idx     <= '0;
        end
        RUN: begin
          sum_q[idx*CHUNK +: CHUNK] <= ks[CHUNK-1:0];
          carry_q <= ks[CHUNK];
          idx     <= idx + 1'b1;
          if (idx == LAST) sum_q[WIDTH] <= ks[CHUNK];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;

endmodule

// File: tb/tb_ksa_chunk_seq.sv
// Self-checking bench for ksa_chunk_seq: directed corner cases plus randomized traffic against a+b+cin.
module tb_ksa_chunk_seq;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;
`ifdef KSA_SEQ_SUB_EN
  logic             op;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ksa_chunk_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef KSA_SEQ_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 65-bit addition, or difference with a no-borrow flag when subtracting.
  function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c, input logic s);
    logic [WIDTH-1:0] d;
    if (s) begin
      d = x - y;
      return {(x >= y), d};
    end
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
  endfunction

  // Starts on a negedge in IDLE; returns the result and the cycles from accept to out_valid.
  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc,
                         input int stall, output logic [WIDTH:0] res, output int lat);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    for (int k = 0; k < stall; k++) @(negedge clk);
    res = sum;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH:0]   res, first;
    logic [WIDTH-1:0] ra, rb;
    logic             rc, ro;
    int               lat, n;

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b0;
`ifdef KSA_SEQ_SUB_EN
    op = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 65'(in_ready), 65'd1);
    chk("rst_out_valid", 65'(out_valid), 65'd0);
    chk("rst_busy", 65'(busy), 65'd0);
    chk("rst_sum", sum, 65'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Carry rippling through every slice.
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, res, lat);
    chk("carry_all", res, 65'h1_0000_0000_0000_0000);
    chk("latency", 65'(lat), 65'(NCHUNK));
    chk("idle_after", 65'(in_ready), 65'd1);

    run_txn(64'h0000_FFFF_0000_FFFF, 64'd1, 1'b1, 0, res, lat);
    chk("carry_partial", res, 65'h0_0000_FFFF_0001_0001);

    // Backpressure with in_valid held high throughout.
    in_valid = 1'b1;
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'hFEDC_BA98_7654_3210;
    cin = 1'b0;
    @(negedge clk);
    a = 64'h0000_0000_0000_0100;
    b = 64'h0000_0000_0000_0023;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    first = ref_model(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_sum", sum, first);
      chk("bp_out_valid", 65'(out_valid), 65'd1);
      chk("bp_in_ready", 65'(in_ready), 65'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_back_idle", 65'(in_ready), 65'd1);
    chk("bp_out_drop", 65'(out_valid), 65'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_busy", 65'(busy), 65'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second_sum", sum, 65'h0_0000_0000_0000_0123);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while two slices have already been written.
    in_valid = 1'b1;
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = 64'hFFFF_FFFF_FFFF_FFFF;
    cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 65'(out_valid), 65'd0);
    chk("mid_rst_sum", sum, 65'd0);
    chk("mid_rst_in_ready", 65'(in_ready), 65'd1);
    chk("mid_rst_busy", 65'(busy), 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(64'd3, 64'd4, 1'b0, 0, res, lat);
    chk("after_rst", res, 65'd7);

`ifdef KSA_SEQ_SUB_EN
    op = 1'b1;
    run_txn(64'd5, 64'd7, 1'b1, 0, res, lat);
    chk("sub_borrow", res, 65'h0_FFFF_FFFF_FFFF_FFFE);
    run_txn(64'd7, 64'd5, 1'b0, 1, res, lat);
    chk("sub_noborrow", res, 65'h1_0000_0000_0000_0002);
    op = 1'b0;
`endif

    for (int t = 0; t < 3000; t++) begin
      case ($urandom_range(0, 5))
        0:       ra = '1;
        1:       ra = '0;
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0:       rb = '1;
        1:       rb = 64'd1;
        default: rb = {$urandom, $urandom};
      endcase
      rc = 1'($urandom_range(0, 1));
      ro = 1'b0;
`ifdef KSA_SEQ_SUB_EN
      op = 1'($urandom_range(0, 1));
      ro = op;
`endif
      run_txn(ra, rb, rc, $urandom_range(0, 3), res, lat);
      chk("random_sum", res, ref_model(ra, rb, rc, ro));
      if (lat != NCHUNK) chk("random_latency", 65'(lat), 65'(NCHUNK));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
